bcd_stopwatch: RTL and testbench
================================

// Module: bcd_stopwatch
// PURPOSE
//  Upstream time source for the seven-segment display chain. Divides the 12 MHz
//  system clock to a tick, counts ticks as NUMCELLS packed BCD digits, and drives
//  them to the BCD-to-segment decode stage. Run/pause/clear are controlled by
//  single-cycle pulses.
// PARAMETERS
//  NUMCELLS  4           number of BCD digits; digit 0 is least significant, at elapsed[3:0]
//  CLK_HZ    12_000_000  input clock frequency
//  TICK_HZ   100         count rate (100 = centiseconds); DIV = CLK_HZ/TICK_HZ, must be >= 2
// PORTS
//  clock       in   1             system clock
//  rst         in   1             synchronous, active-high reset
//  start_stop  in   1             1-cycle pulse; toggles run/pause
//  clear       in   1             1-cycle pulse; zeroes count, stops
//  lap         in   1             1-cycle pulse; display freeze toggle (STOPWATCH_LAP_EN)
//  elapsed     out  4*NUMCELLS    packed BCD count to the display decoder
//  running     out  1             high in RUN
//  overflow    out  1             high in OVF (count saturated at all 9s)
// BEHAVIOUR
//  - Interface: one clock (clock); reset rst is synchronous and active-high.
//  - Reset: state=IDLE, prescaler=0, count=0, elapsed=0, running=0, overflow=0,
//    lap freeze cleared. rst overrides every other input in the same cycle.
//  - FSM states: IDLE, RUN, PAUSE, OVF.
//    IDLE  -start_stop-> RUN (prescaler forced to 0)
//    RUN   -start_stop-> PAUSE (prescaler holds its partial value)
//    PAUSE -start_stop-> RUN (resumes from the held prescaler value)
//    RUN   -tick while count = all 9s-> OVF
//    any non-IDLE state -clear-> IDLE
//    In OVF, start_stop is ignored; only clear exits.
//  - Priority: rst > clear > start_stop > tick. If clear and start_stop arrive in the
//    same cycle, the result is IDLE.
//  - Prescaler: counts 0..DIV-1 only in RUN. tick = RUN && prescaler==DIV-1; on tick
//    the prescaler wraps to 0.
//  - Count: ripple-carry BCD increment on the tick edge. Digit 9 -> 0 with carry;
//    no digit ever holds a value above 9.
//    Tick at all 9s: count stays all 9s, state -> OVF; no wrap to 0.
//  - Latency: elapsed, running and overflow are registered and change on the clock
//    edge that updates state/count; there is no combinational path from input to output.
//  - Clear: count=0 and prescaler=0 on the next edge, in any state.
//  - start_stop arriving in the same cycle as a tick: the tick's increment is kept,
//    then the FSM moves to PAUSE.
// CONFIGURATION
//  STOPWATCH_LAP_EN defined:
//    - lap in RUN or PAUSE toggles freeze.
//    - While frozen, elapsed holds the count snapshot taken on the lap edge; the
//      internal count keeps advancing.
//    - Unfreeze: elapsed tracks the count again on the next edge.
//    - clear and rst also unfreeze. lap is ignored in IDLE and OVF.
//  STOPWATCH_LAP_EN undefined: the lap port exists but is ignored, there is no
//    snapshot register, and elapsed always equals the count.
// STRUCTURE
//  - stopwatch_pkg holds:
//    - the state encoding (IDLE/RUN/PAUSE/OVF, 2 bits);
//    - BCD_MAX = 4'd9;
//    - DIV and prescaler-width ($clog2(DIV)) derivation.
//  - Sub-module bcd_digit_counter: one 4-bit digit with inc_in, carry_out and a
//    synchronous clear. Instantiated NUMCELLS times via generate, carry chained
//    from digit 0 upward.
// TESTING
//  Bench uses CLK_HZ=10, TICK_HZ=1 (DIV=10), NUMCELLS=4.
//  1 Reset: rst high 3 cycles -> elapsed=16'h0000, running=0, overflow=0.
//  2 Run/increment:
//    - start_stop pulse -> running=1.
//    - After 10 cycles elapsed=16'h0001; after 100 cycles elapsed=16'h0010.
//  3 Pause/resume:
//    - Pause at prescaler=4 -> elapsed frozen for 50 cycles.
//    - Resume -> next increment after 6 more cycles.
//  4 Overflow:
//    - Preload via 9999 ticks -> elapsed=16'h9999.
//    - Next tick -> still 16'h9999, overflow=1, running=0.
//    - start_stop ignored; clear -> 16'h0000, overflow=0.
//  5 Clear+start_stop in the same cycle while in RUN -> IDLE, elapsed=0, running=0.
//  6 (STOPWATCH_LAP_EN) lap at 16'h0012 -> elapsed holds 12 while the count reaches
//    0015; second lap -> elapsed=16'h0015 next edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: FSM encoding, digit limit,
// and prescaler divide/width derivation from the clock and count rates.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVF   = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // A DIV of 2 still needs one bit, so the width never collapses to zero.
    function automatic int presc_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit (0..9) with ripple carry in/out, synchronous clear, and a hold
// input that suppresses the increment when the whole counter is saturated.
module bcd_digit_counter
    import stopwatch_pkg::*;
(
    input  logic       clock,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       inc_i,
    input  logic       hold_i,
    output logic [3:0] digit_o,
    output logic       carry_o
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clear_i) begin
            digit_d = 4'd0;
        end else if (inc_i && !hold_i) begin
            digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    // Carry is based on the unheld increment so the top carry flags a tick at all 9s.
    assign carry_o = inc_i && (digit_q == BCD_MAX);
    assign digit_o = digit_q;

endmodule

// File: rtl/bcd_stopwatch.sv
// Prescaled BCD stopwatch with run/pause/clear pulses and saturating overflow.
// Optional display freeze (lap) is enabled by defining STOPWATCH_LAP_EN.
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int NUMCELLS = 4,
    parameter int CLK_HZ   = 12_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start_stop,
    input  logic                  clear,
    input  logic                  lap,
    output logic [4*NUMCELLS-1:0] elapsed,
    output logic                  running,
    output logic                  overflow
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int PW  = presc_width(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    state_e                state_q;
    state_e                state_d;
    logic [PW-1:0]         presc_q;
    logic [PW-1:0]         presc_d;
    logic                  tick;
    logic                  saturate;
    logic [NUMCELLS:0]     carry;
    logic [4*NUMCELLS-1:0] count;

    assign tick     = (state_q == RUN) && (presc_q == PRESC_LAST);
    assign carry[0] = tick;
    assign saturate = carry[NUMCELLS];

    generate
        for (genvar gi = 0; gi < NUMCELLS; gi++) begin : g_digit
            bcd_digit_counter u_digit (
                .clock   (clock),
                .rst     (rst),
                .clear_i (clear),
                .inc_i   (carry[gi]),
                .hold_i  (saturate),
                .digit_o (count[4*gi +: 4]),
                .carry_o (carry[gi+1])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        if (clear) begin
            state_d = IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_stop) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    if (tick) begin
                        presc_d = '0;
                    end else if (!start_stop) begin
                        presc_d = presc_q + PW'(1);
                    end
                    if (start_stop) begin
                        state_d = PAUSE;
                    end else if (saturate) begin
                        state_d = OVF;
                    end
                end
                PAUSE: begin
                    if (start_stop) begin
                        state_d = RUN;
                    end
                end
                OVF: begin
                    state_d = OVF;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
        end
    end

    assign running  = (state_q == RUN);
    assign overflow = (state_q == OVF);

`ifdef STOPWATCH_LAP_EN
    logic                  frozen_q;
    logic                  frozen_d;
    logic [4*NUMCELLS-1:0] snap_q;
    logic [4*NUMCELLS-1:0] snap_d;

    always_comb begin
        frozen_d = frozen_q;
        snap_d   = snap_q;
        if (clear) begin
            frozen_d = 1'b0;
        end else if (lap && ((state_q == RUN) || (state_q == PAUSE))) begin
            frozen_d = !frozen_q;
            if (!frozen_q) begin
                snap_d = count;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            frozen_q <= 1'b0;
            snap_q   <= '0;
        end else begin
            frozen_q <= frozen_d;
            snap_q   <= snap_d;
        end
    end

    assign elapsed = frozen_q ? snap_q : count;
`else
    logic lap_unused;
    assign lap_unused = lap;
    assign elapsed    = count;
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Scoreboard bench for bcd_stopwatch: a DIV=10 instance for timing tests and a
// DIV=2 instance so the 9999-tick overflow run stays short.
module tb_bcd_stopwatch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ss = 1'b0, clr = 1'b0, lap = 1'b0;
    logic        ss_f = 1'b0, clr_f = 1'b0, lap_f = 1'b0;
    logic [15:0] el_m, el_f;
    logic        run_m, run_f, ovf_m, ovf_f;

    always #5 clk = ~clk;

    bcd_stopwatch #(.NUMCELLS(4), .CLK_HZ(10), .TICK_HZ(1)) u_dut (
        .clock(clk), .rst(rst), .start_stop(ss), .clear(clr), .lap(lap),
        .elapsed(el_m), .running(run_m), .overflow(ovf_m)
    );

    bcd_stopwatch #(.NUMCELLS(4), .CLK_HZ(2), .TICK_HZ(1)) u_dut_fast (
        .clock(clk), .rst(rst), .start_stop(ss_f), .clear(clr_f), .lap(lap_f),
        .elapsed(el_f), .running(run_f), .overflow(ovf_f)
    );

    typedef struct {
        string       name;
        bit          fast;
        logic [15:0] el;
        logic        run;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input bit fast, input logic [15:0] el,
                              input logic run, input logic ovf);
        exp_t e;
        e.name = name; e.fast = fast; e.el = el; e.run = run; e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    task automatic pulse_ss();    ss = 1'b1;    step(1); ss = 1'b0;    endtask
    task automatic pulse_lap();   lap = 1'b1;   step(1); lap = 1'b0;   endtask
    task automatic pulse_clr();   clr = 1'b1;   step(1); clr = 1'b0;   endtask
    task automatic pulse_ss_f();  ss_f = 1'b1;  step(1); ss_f = 1'b0;  endtask
    task automatic pulse_clr_f(); clr_f = 1'b1; step(1); clr_f = 1'b0; endtask

    // Monitor: compares queued expectations on the falling edge, away from updates.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [15:0] a_el;
        logic        a_run, a_ovf;
        while (exp_q.size() > 0) begin
            e     = exp_q.pop_front();
            a_el  = e.fast ? el_f  : el_m;
            a_run = e.fast ? run_f : run_m;
            a_ovf = e.fast ? ovf_f : ovf_m;
            checks++;
            if (a_el !== e.el) begin
                errors++;
                $display("FAIL %s elapsed actual=%h required=%h", e.name, a_el, e.el);
            end
            checks++;
            if (a_run !== e.run) begin
                errors++;
                $display("FAIL %s running actual=%b required=%b", e.name, a_run, e.run);
            end
            checks++;
            if (a_ovf !== e.ovf) begin
                errors++;
                $display("FAIL %s overflow actual=%b required=%b", e.name, a_ovf, e.ovf);
            end
            $display("check %s: elapsed=%h running=%b overflow=%b", e.name, a_el, a_run, a_ovf);
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin : stimulus
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        expect_out("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
        expect_out("reset_fast", 1'b1, 16'h0000, 1'b0, 1'b0);
        step(1);

        // Run and increment
        pulse_ss();
        expect_out("start", 1'b0, 16'h0000, 1'b1, 1'b0);
        step(9);
        expect_out("before_tick", 1'b0, 16'h0000, 1'b1, 1'b0);
        step(1);
        expect_out("tick1", 1'b0, 16'h0001, 1'b1, 1'b0);
        step(90);
        expect_out("tick10", 1'b0, 16'h0010, 1'b1, 1'b0);

        // Pause at prescaler=4, resume needs 6 more cycles
        step(4);
        pulse_ss();
        expect_out("pause", 1'b0, 16'h0010, 1'b0, 1'b0);
        step(50);
        expect_out("paused50", 1'b0, 16'h0010, 1'b0, 1'b0);
        pulse_ss();
        expect_out("resume", 1'b0, 16'h0010, 1'b1, 1'b0);
        step(5);
        expect_out("resume5", 1'b0, 16'h0010, 1'b1, 1'b0);
        step(1);
        expect_out("resume6", 1'b0, 16'h0011, 1'b1, 1'b0);

        // Clear and start_stop together in RUN
        ss = 1'b1; clr = 1'b1;
        step(1);
        ss = 1'b0; clr = 1'b0;
        expect_out("clear_and_ss", 1'b0, 16'h0000, 1'b0, 1'b0);

        // start_stop on the tick edge keeps the increment, then pauses
        pulse_ss();
        step(9);
        pulse_ss();
        expect_out("ss_on_tick", 1'b0, 16'h0001, 1'b0, 1'b0);
        step(20);
        expect_out("paused_after_tick", 1'b0, 16'h0001, 1'b0, 1'b0);

        // Lap freeze (or lap ignored when the feature is absent)
        pulse_ss();
        step(110);
        expect_out("count12", 1'b0, 16'h0012, 1'b1, 1'b0);
        pulse_lap();
        expect_out("lap1", 1'b0, 16'h0012, 1'b1, 1'b0);
        step(29);
`ifdef STOPWATCH_LAP_EN
        expect_out("lap_frozen", 1'b0, 16'h0012, 1'b1, 1'b0);
`else
        expect_out("lap_ignored", 1'b0, 16'h0015, 1'b1, 1'b0);
`endif
        pulse_lap();
        expect_out("lap2", 1'b0, 16'h0015, 1'b1, 1'b0);
        pulse_lap();
        pulse_clr();
        expect_out("clear_frozen", 1'b0, 16'h0000, 1'b0, 1'b0);

        // Overflow on the DIV=2 instance
        pulse_ss_f();
        expect_out("f_start", 1'b1, 16'h0000, 1'b1, 1'b0);
        step(19998);
        expect_out("f_9999", 1'b1, 16'h9999, 1'b1, 1'b0);
        step(2);
        expect_out("f_ovf", 1'b1, 16'h9999, 1'b0, 1'b1);
        pulse_ss_f();
        expect_out("f_ss_ignored", 1'b1, 16'h9999, 1'b0, 1'b1);
        step(5);
        expect_out("f_hold", 1'b1, 16'h9999, 1'b0, 1'b1);
        pulse_clr_f();
        expect_out("f_clear", 1'b1, 16'h0000, 1'b0, 1'b0);

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
